// File: rtl/system_bus_pkg.sv
// rtl/system_bus_pkg.sv - shared types and default widths for the serial system bus ports
package system_bus_pkg;

  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_RD_TIMEOUT = 64;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_OUT,
    DATA_OUT,
    WAIT_RD,
    RD_IN,
    DONE
  } mst_state_t;

endpackage

// File: rtl/master_port_if.sv
// rtl/master_port_if.sv - local request side and serial slave lines of the master port
interface master_port_if import system_bus_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                  req;
  logic                  req_mode;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  req_ready;
  logic                  rsp_valid;
  logic                  rsp_err;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  mode;
  logic                  wr_bus;
  logic                  master_valid;
  logic                  master_ready;
  logic                  slave_ready;
  logic                  slave_valid;
  logic                  rd_bus;

  modport master (
    input  req, req_mode, req_addr, req_wdata, slave_ready, slave_valid, rd_bus,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, mode, wr_bus, master_valid, master_ready
  );

  modport slave (
    output req, req_mode, req_addr, req_wdata, slave_ready, slave_valid, rd_bus,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, mode, wr_bus, master_valid, master_ready
  );

endinterface

// File: rtl/master_port_shift_reg.sv
// rtl/master_port_shift_reg.sv - parallel-load shift register, MSB-first out, LSB-side in
module serial_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_par,
  input  logic             i_shift,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_par
);

  logic [WIDTH-1:0] r_data;

  // load wins over shift; the serial output is o_par[WIDTH-1]
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_par;
    end else if (i_shift) begin
      r_data <= {r_data[WIDTH-2:0], i_sin};
    end
  end

  assign o_par = r_data;

endmodule

// File: rtl/master_port.sv
// rtl/master_port.sv - bit-serial bus initiator: shifts address/write data out, collects read data
module master_port import system_bus_pkg::*; #(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RD_TIMEOUT = DEF_RD_TIMEOUT
) (
  input logic          clk,
  input logic          rstn,
  master_port_if.master bus
);

  localparam int TX_WIDTH = ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W    = $clog2(TX_WIDTH + 1);
  localparam int TO_W     = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(TX_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_RD   = CNT_W'(DATA_WIDTH - 1);
  localparam logic [TO_W-1:0]  LAST_TO   = TO_W'(RD_TIMEOUT - 1);

  mst_state_t            r_state, w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [TO_W-1:0]       r_to;
  logic                  r_mode;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic                  w_master_valid, w_master_ready;
  logic                  w_accept, w_capture;
  logic                  w_tx_load, w_set_err, w_rd_done;
  logic [TX_WIDTH-1:0]   w_tx_par;
  logic [DATA_WIDTH-1:0] w_rx_par, w_rx_next;

  assign w_master_valid = (r_state == ADDR_OUT) || (r_state == DATA_OUT);
  assign w_master_ready = (r_state == WAIT_RD) || (r_state == RD_IN);
  assign w_accept       = w_master_valid && bus.slave_ready;
  assign w_capture      = w_master_ready && bus.slave_valid;
  assign w_rx_next      = {w_rx_par[DATA_WIDTH-2:0], bus.rd_bus};

  serial_shift_reg #(.WIDTH(TX_WIDTH)) u_tx (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_tx_load),
    .i_par   ({bus.req_addr, bus.req_wdata}),
    .i_shift (w_accept),
    .i_sin   (1'b0),
    .o_par   (w_tx_par)
  );

  serial_shift_reg #(.WIDTH(DATA_WIDTH)) u_rx (
    .clk     (clk),
    .rstn    (rstn),
    .i_load  (w_tx_load),
    .i_par   ('0),
    .i_shift (w_capture),
    .i_sin   (bus.rd_bus),
    .o_par   (w_rx_par)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_tx_load = 1'b0;
    w_set_err = 1'b0;
    w_rd_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          w_tx_load = 1'b1;
          w_next    = ADDR_OUT;
        end
      end
      // before the first accepted bit the slave may stall freely; afterwards a gap is an abort
      ADDR_OUT: begin
        if (w_accept) begin
          if (r_cnt == LAST_ADDR) w_next = (r_mode == MODE_WRITE) ? DATA_OUT : WAIT_RD;
        end else if (r_cnt != '0) begin
          w_set_err = 1'b1;
          w_next    = DONE;
        end
      end
      DATA_OUT: begin
        if (w_accept) begin
          if (r_cnt == LAST_DATA) w_next = DONE;
        end else begin
          w_set_err = 1'b1;
          w_next    = DONE;
        end
      end
      WAIT_RD: begin
        if (bus.slave_valid) begin
          w_next = RD_IN;
        end else if (r_to == LAST_TO) begin
          w_set_err = 1'b1;
          w_next    = DONE;
        end
      end
      RD_IN: begin
        if (bus.slave_valid) begin
          if (r_cnt == LAST_RD) begin
            w_rd_done = 1'b1;
            w_next    = DONE;
          end
        end else begin
          w_set_err = 1'b1;
          w_next    = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // r_cnt counts wr_bus bits through ADDR_OUT/DATA_OUT, then restarts as the read-bit count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt   <= '0;
      r_to    <= '0;
      r_mode  <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req) begin
            r_mode <= bus.req_mode;
            r_cnt  <= '0;
            r_to   <= '0;
            r_err  <= 1'b0;
          end
        end
        ADDR_OUT, DATA_OUT: if (w_accept) r_cnt <= r_cnt + CNT_W'(1);
        WAIT_RD: begin
          if (bus.slave_valid) r_cnt <= CNT_W'(1);
          else                 r_to  <= r_to + TO_W'(1);
        end
        RD_IN: if (w_capture) r_cnt <= r_cnt + CNT_W'(1);
        DONE: begin
          r_mode <= 1'b0;
          r_cnt  <= '0;
          r_to   <= '0;
          r_err  <= 1'b0;
        end
        default: ;
      endcase
      if (w_set_err) r_err   <= 1'b1;
      if (w_rd_done) r_rdata <= w_rx_next;
    end
  end

  assign bus.req_ready    = (r_state == IDLE);
  assign bus.master_valid = w_master_valid;
  assign bus.master_ready = w_master_ready;
  assign bus.wr_bus       = w_master_valid & w_tx_par[TX_WIDTH-1];
  assign bus.mode         = r_mode;
  assign bus.rsp_valid    = (r_state == DONE);
  assign bus.rsp_err      = (r_state == DONE) & r_err;
  assign bus.rsp_rdata    = r_rdata;

endmodule

// File: tb/tb_master_port.sv
// tb/tb_master_port.sv - randomized scoreboard bench for master_port with a behavioural slave
module tb_master_port;
  import system_bus_pkg::*;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 64;
  localparam int TW = AW + DW;
  localparam int NO_ABORT = 999;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  master_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic          err;
    logic [DW-1:0] rdata;
    int            nbits;
    logic [TW-1:0] bits;
    int            mr;
    int            lat;
    int            req_cyc;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rsp_seen = 0;

  logic          cfg_mode = 1'b0;
  int            cfg_sr_delay = 0, cfg_abort = NO_ABORT, cfg_rd_delay = 0, cfg_rd_bits = DW;
  logic [DW-1:0] cfg_word = '0;
  int            mv_cyc = 0, taken = 0, mr_cyc = 0, sent = 0, mode_bad = 0;
  logic [TW-1:0] got_bits = '0;
  logic [DW-1:0] ref_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // transaction outcome from the protocol rules: bits seen, error, read word, handshake length
  function automatic exp_t model(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] w,
                                 input int srd, input int ab, input int rdd, input int rdb,
                                 input logic [DW-1:0] word);
    exp_t e;
    int nb;
    logic [TW-1:0] full;
    nb = m ? TW : AW;
    full = m ? {a, w} : TW'(a);
    e.lat = -1;
    e.req_cyc = 0;
    e.mr = 0;
    if (ab < nb) begin
      e.err = 1'b1;
      e.nbits = ab;
      e.bits = full >> (nb - ab);
    end else begin
      e.err = 1'b0;
      e.nbits = nb;
      e.bits = full;
      if (m) begin
        e.lat = srd + TW + 1;
      end else if (rdb == 0) begin
        e.err = 1'b1;
        e.mr = TO;
      end else if (rdb < DW) begin
        e.err = 1'b1;
        e.mr = rdd + rdb + 1;
      end else begin
        e.mr = rdd + DW;
        ref_rdata = word;
      end
    end
    e.rdata = ref_rdata;
    return e;
  endfunction

  // behavioural slave: decides its inputs at negedge, so a bit moves at the following posedge
  initial begin
    bus.slave_ready = 1'b0;
    bus.slave_valid = 1'b0;
    bus.rd_bus = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.req_ready) begin
        mv_cyc = 0; taken = 0; mr_cyc = 0; sent = 0; mode_bad = 0; got_bits = '0;
      end
      bus.slave_ready = bus.master_valid && (mv_cyc >= cfg_sr_delay) && (taken < cfg_abort);
      if (bus.master_valid) mv_cyc++;
      if (bus.slave_ready) begin
        got_bits = {got_bits[TW-2:0], bus.wr_bus};
        taken++;
        if (bus.mode !== cfg_mode) mode_bad++;
      end
      bus.slave_valid = 1'b0;
      if (bus.master_ready) begin
        if (mr_cyc >= cfg_rd_delay && sent < cfg_rd_bits) begin
          bus.slave_valid = 1'b1;
          bus.rd_bus = cfg_word[DW-1-sent];
          sent++;
        end
        mr_cyc++;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && bus.rsp_valid) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
          check("wr_nbits", taken, e.nbits);
          check("wr_bits", 32'(got_bits), 32'(e.bits));
          check("mode_stable", mode_bad, 0);
          check("mr_cycles", mr_cyc, e.mr);
          check("mv_low_at_rsp", 32'(bus.master_valid), 32'(0));
          if (e.lat >= 0) check("latency", cyc - e.req_cyc, e.lat);
        end
        rsp_seen++;
      end
    end
  end

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (!bus.req_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("idle_reached", 32'(bus.req_ready), 32'(1));
  endtask

  task automatic set_cfg(input logic m, input int srd, input int ab, input int rdd, input int rdb,
                         input logic [DW-1:0] word);
    cfg_mode = m; cfg_sr_delay = srd; cfg_abort = ab;
    cfg_rd_delay = rdd; cfg_rd_bits = rdb; cfg_word = word;
  endtask

  task automatic wait_rsp(input int start);
    int guard = 0;
    while (rsp_seen == start && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (rsp_seen == start) begin
      total++; bad++;
      $display("FAIL rsp_timeout: got no rsp_valid expected one within 400 cycles");
      sb.delete();
    end
  endtask

  task automatic issue(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] w,
                       input int srd, input int ab, input int rdd, input int rdb,
                       input logic [DW-1:0] word);
    exp_t e;
    int start;
    wait_idle();
    set_cfg(m, srd, ab, rdd, rdb, word);
    e = model(m, a, w, srd, ab, rdd, rdb, word);
    e.req_cyc = cyc;
    sb.push_back(e);
    start = rsp_seen;
    bus.req = 1'b1; bus.req_mode = m; bus.req_addr = a; bus.req_wdata = w;
    @(negedge clk);
    bus.req = 1'b0;
    wait_rsp(start);
  endtask

  initial begin : stim
    exp_t e;
    int start, guard;
    logic m;
    logic [AW-1:0] a;
    logic [DW-1:0] w, word;
    int srd, ab, rdd, rdb;

    bus.req = 1'b0; bus.req_mode = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'(1));
    check("rst_master_valid", 32'(bus.master_valid), 32'(0));
    check("rst_master_ready", 32'(bus.master_ready), 32'(0));
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("rst_rsp_err", 32'(bus.rsp_err), 32'(0));
    check("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'(0));
    check("rst_mode", 32'(bus.mode), 32'(0));
    check("rst_wr_bus", 32'(bus.wr_bus), 32'(0));
    #2 rstn = 1'b1;

    issue(MODE_WRITE, 16'h0025, 8'hA5, 1, NO_ABORT, 0, DW, 8'h00);
    issue(MODE_READ, 16'h0003, 8'h00, 0, NO_ABORT, 2, DW, 8'h3C);
    issue(MODE_WRITE, 16'hBEEF, 8'h5A, 0, 5, 0, DW, 8'h00);
    issue(MODE_READ, 16'h1234, 8'h00, 0, NO_ABORT, 0, 0, 8'h00);
    issue(MODE_READ, 16'h4321, 8'h00, 0, NO_ABORT, 1, 3, 8'hF0);

    // asynchronous reset in the middle of DATA_OUT
    wait_idle();
    set_cfg(MODE_WRITE, 0, NO_ABORT, 0, DW, 8'h00);
    bus.req = 1'b1; bus.req_mode = MODE_WRITE; bus.req_addr = 16'hCAFE; bus.req_wdata = 8'h77;
    @(negedge clk);
    bus.req = 1'b0;
    guard = 0;
    while (taken < AW + 3 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("pre_rst_in_data", 32'(bus.master_valid), 32'(1));
    #2 rstn = 1'b0;
    #1;
    check("arst_master_valid", 32'(bus.master_valid), 32'(0));
    check("arst_mode", 32'(bus.mode), 32'(0));
    check("arst_req_ready", 32'(bus.req_ready), 32'(1));
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'(0));
    check("arst_rsp_rdata", 32'(bus.rsp_rdata), 32'(0));
    ref_rdata = '0;
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    issue(MODE_WRITE, 16'h0F0F, 8'h3C, 2, NO_ABORT, 0, DW, 8'h00);

    // req held high across a completing transaction
    wait_idle();
    set_cfg(MODE_WRITE, 0, NO_ABORT, 0, DW, 8'h00);
    e = model(MODE_WRITE, 16'h8001, 8'hC3, 0, NO_ABORT, 0, DW, 8'h00);
    e.req_cyc = cyc;
    sb.push_back(e);
    e = model(MODE_WRITE, 16'h8001, 8'hC3, 0, NO_ABORT, 0, DW, 8'h00);
    e.lat = -1;
    sb.push_back(e);
    bus.req = 1'b1; bus.req_mode = MODE_WRITE; bus.req_addr = 16'h8001; bus.req_wdata = 8'hC3;
    guard = 0;
    @(negedge clk);
    while (!bus.rsp_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("held_first_rsp", 32'(bus.rsp_valid), 32'(1));
    start = rsp_seen;
    @(negedge clk);
    check("held_req_ready_gap", 32'(bus.req_ready), 32'(1));
    @(negedge clk);
    check("held_second_started", 32'(bus.req_ready), 32'(0));
    bus.req = 1'b0;
    if (rsp_seen == start) wait_rsp(start);
    else wait_rsp(start + 1);

    for (int i = 0; i < 40; i++) begin
      m    = 1'($urandom_range(0, 1));
      a    = AW'($urandom);
      w    = DW'($urandom);
      word = DW'($urandom);
      srd  = int'($urandom_range(0, 4));
      ab   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, m ? TW - 1 : AW - 1)) : NO_ABORT;
      rdd  = int'($urandom_range(0, 8));
      rdb  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, DW - 1)) : DW;
      issue(m, a, w, srd, ab, rdd, rdb, word);
    end

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/master_port.md
Name: master_port

Overview:
- Bit-serial initiator for the system bus; the opposite end of the serial slave port.
- Accepts a parallel read/write request from a local controller and shifts the address, then any write data, MSB first on wr_bus.
- For reads, it collects DATA_WIDTH serial bits from rd_bus and returns them as a parallel word.
- Sits between the bus arbiter/controller and the serial lines to one slave.

Parameters:
- ADDR_WIDTH, 16, address bits shifted per transaction.
- DATA_WIDTH, 8, data bits per transaction.
- RD_TIMEOUT, 64, max cycles to wait for slave_valid before the read is abandoned.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- req  input  1  local request strobe; sampled only when req_ready=1
- req_mode  input  1  1=write, 0=read
- req_addr  input  ADDR_WIDTH  target address
- req_wdata  input  DATA_WIDTH  write data
- req_ready  output  1  high in IDLE; master can accept a request
- rsp_valid  output  1  one-cycle pulse: transaction complete
- rsp_err  output  1  one-cycle pulse with rsp_valid on abort or timeout
- rsp_rdata  output  DATA_WIDTH  read data; held until the next read completes
- mode  output  1  transaction mode to the slave; stable from the first valid cycle to the end
- wr_bus  output  1  serial address/write data, MSB first
- master_valid  output  1  master has a bit on wr_bus
- master_ready  output  1  master will sample rd_bus
- slave_ready  input  1  slave samples wr_bus this cycle
- slave_valid  input  1  slave drives a read bit on rd_bus
- rd_bus  input  1  serial read data, MSB first

Behaviour:
- Reset values (async, rstn=0): state IDLE, all outputs 0 except req_ready=1, rsp_rdata=0, internal shift registers and counter cleared.
- Reset mid-transaction aborts immediately; no rsp_valid is produced.
- Transfer rule: a bit moves on a cycle when master_valid && slave_ready.
  - The shift register then advances and the counter increments.
  - Otherwise wr_bus holds.
- Read-bit rule: a bit is captured on a cycle when slave_valid && master_ready.
- States:
  - IDLE: req_ready=1. On req:
    - latch {req_addr, req_wdata} into the TX shift register and mode<=req_mode;
    - clear the counter;
    - go to ADDR_OUT.
  - ADDR_OUT: master_valid=1, wr_bus=TX MSB.
    - Before the first accepted bit, wait indefinitely for slave_ready.
    - After at least one accepted bit, slave_ready=0 is an abort: go to DONE with err.
    - When the ADDR_WIDTH-th bit is accepted (counter==ADDR_WIDTH-1 and accepted): go to DATA_OUT if mode=1, else WAIT_RD.
  - DATA_OUT: same shift and abort rules.
    - After the DATA_WIDTH-th data bit is accepted: drop master_valid and go to DONE with no error.
  - WAIT_RD: master_valid=0, master_ready=1, timeout counter runs.
    - First slave_valid: capture rd_bus as bit DATA_WIDTH-1, go to RD_IN.
    - Timeout counter reaching RD_TIMEOUT-1 with no slave_valid: go to DONE with err.
  - RD_IN: master_ready=1; each accepted bit shifts into RX LSB-side, MSB arriving first.
    - After DATA_WIDTH bits: rsp_rdata<=RX, go to DONE.
    - slave_valid dropping before DATA_WIDTH bits: err, go to DONE.
  - DONE: rsp_valid=1 for exactly one cycle (rsp_err as flagged), mode<=0, return to IDLE.
- Latency (write, slave always ready after a 1-cycle response): req cycle → IDLE exit; ADDR_WIDTH+DATA_WIDTH accepted cycles; rsp_valid one cycle after the last bit.
- Counter width is $clog2(ADDR_WIDTH+DATA_WIDTH+1). The timeout counter is sized from RD_TIMEOUT. Neither counter wraps; both are cleared on entry to IDLE.
- req asserted outside IDLE is ignored; it is not queued.
- rsp_rdata is not updated on writes or on errored reads.

Decomposition:
- Package system_bus_pkg:
  - state enum mst_state_t {IDLE, ADDR_OUT, DATA_OUT, WAIT_RD, RD_IN, DONE};
  - MODE_READ/MODE_WRITE constants;
  - default width constants shared with the slave port.
- Sub-module: one natural one, serial_shift_reg (parameterised width, load/shift enable, serial in/out), instantiated for TX and RX.

Test Plan:
- Write, addr=0x0025, wdata=0xA5, slave_ready high from the second cycle:
  - wr_bus sequence is 16 address bits 0000000000100101 then 10100101, with mode=1 throughout;
  - one rsp_valid pulse with rsp_err=0.
- Read, addr=0x0003, slave returns 0x3C with 2 idle cycles before slave_valid:
  - 16 address bits, then master_ready=1;
  - rsp_rdata=0x3C, rsp_valid pulse, rsp_err=0.
- Slave deasserts slave_ready after the 5th address bit:
  - master_valid drops;
  - rsp_valid=1 and rsp_err=1 in the same cycle;
  - back in IDLE with req_ready=1.
- Read with no slave_valid for RD_TIMEOUT=64 cycles:
  - rsp_err pulse at cycle 64 of WAIT_RD;
  - rsp_rdata keeps its previous value.
- rstn pulsed low during DATA_OUT bit 3:
  - asynchronously master_valid=0, mode=0, req_ready=1;
  - no rsp_valid;
  - a subsequent write completes cleanly.
- req held high across a completing transaction:
  - the second transaction starts only from IDLE, with req_ready=1 for at least one cycle between transactions.
